// File: rtl/edge_pulse_gen.sv
// edge_pulse_gen: serialises single-cycle event requests into fixed-width high pulses.
// Each pulse is followed by a guaranteed low gap. Optional `done` pulse under EDGE_GEN_DONE_EN.
//
// Handshake: `ev` has no back-pressure. Every cycle with ev=1 is one event.
// The event is started immediately, queued in pend_cnt, or dropped. A dropped event is flagged by a one-cycle `ovf`.

module edge_pulse_gen #(
    parameter int HIGH_CYC = 3,
    parameter int LOW_CYC  = 2,
    parameter int PEND_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ev,
    output logic              sig,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              ovf,
    output logic [1:0]        state_dbg
`ifdef EDGE_GEN_DONE_EN
    ,
    output logic              done
`endif
);

    localparam int MAX_PH = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
    localparam int CNT_W  = $clog2(MAX_PH + 1);
    localparam logic [CNT_W-1:0]  HIGH_LD  = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0]  LOW_LD   = CNT_W'(LOW_CYC - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [PEND_W-1:0]   pend_nxt;
    logic                consume;
    logic                deq;
    logic                enq;
    logic                drop;

    assign state_dbg = state;

    // sig/busy come from next-state so they are clean flops aligned with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pend_cnt <= '0;
            sig      <= 1'b0;
            busy     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pend_cnt <= pend_nxt;
            sig      <= (state_nxt == HIGH);
            busy     <= (state_nxt != IDLE);
            ovf      <= drop;
        end
    end

`ifdef EDGE_GEN_DONE_EN
    // Fires in the first LOW cycle; a high period cut short by reset never gets here.
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state == HIGH) && (cnt == '0);
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        consume   = 1'b0;
        deq       = 1'b0;
        enq       = 1'b0;
        drop      = 1'b0;
        pend_nxt  = pend_cnt;

        case (state)
            IDLE: begin
                if (ev) begin
                    state_nxt = HIGH;
                    cnt_nxt   = HIGH_LD;
                    consume   = 1'b1;
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    state_nxt = LOW;
                    cnt_nxt   = LOW_LD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            LOW: begin
                if (cnt == '0) begin
                    // Queued work has priority over a fresh request on the last low cycle.
                    if (pend_cnt != '0) begin
                        state_nxt = HIGH;
                        cnt_nxt   = HIGH_LD;
                        deq       = 1'b1;
                    end else if (ev) begin
                        state_nxt = HIGH;
                        cnt_nxt   = HIGH_LD;
                        consume   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        enq = ev && !consume;
        if (enq && !deq) begin
            if (pend_cnt == PEND_MAX) begin
                drop = 1'b1;
            end else begin
                pend_nxt = pend_cnt + 1'b1;
            end
        end else if (deq && !enq) begin
            pend_nxt = pend_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Bench for edge_pulse_gen: directed scenarios plus random traffic, checked against a
// period-timeline reference model. Handles both EDGE_GEN_DONE_EN builds.

module tb_edge_pulse_gen;

    localparam int H    = 3;
    localparam int L    = 2;
    localparam int PW   = 2;
    localparam int P    = H + L;
    localparam int MAXP = (1 << PW) - 1;
    localparam int W    = PW + 4;
`ifdef EDGE_GEN_DONE_EN
    localparam bit HAS_DONE = 1'b1;
`else
    localparam bit HAS_DONE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ev;
    logic          sig;
    logic          busy;
    logic [PW-1:0] pend_cnt;
    logic          ovf;
    logic [1:0]    state_dbg;
    logic          done_w;

`ifdef EDGE_GEN_DONE_EN
    logic done;
    assign done_w = done;
`else
    assign done_w = 1'b0;
`endif

    edge_pulse_gen #(.HIGH_CYC(H), .LOW_CYC(L), .PEND_W(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ev        (ev),
        .sig       (sig),
        .busy      (busy),
        .pend_cnt  (pend_cnt),
        .ovf       (ovf),
        .state_dbg (state_dbg)
`ifdef EDGE_GEN_DONE_EN
        ,
        .done      (done)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int m_start  = -1;   // first cycle of the current high period, -1 when idle
    int m_pend   = 0;
    logic [W-1:0] exp_q[$];

    function automatic bit m_active(input int c);
        return (m_start >= 0) && (c >= m_start) && (c <= m_start + P - 1);
    endfunction

    // Advances the model over the edge that ends cycle k and queues the outputs expected in k+1.
    task automatic model_step(input bit e, input bit r);
        int k;
        int c;
        bit drop;
        bit e_sig, e_busy, e_done;
        k    = cyc;
        c    = k + 1;
        drop = 1'b0;
        if (r) begin
            m_start = -1;
            m_pend  = 0;
        end else if (!m_active(k)) begin
            m_start = e ? k + 1 : -1;
        end else if (k == m_start + P - 1) begin
            if (m_pend > 0) begin
                m_pend  = m_pend - 1 + (e ? 1 : 0);
                m_start = k + 1;
            end else if (e) begin
                m_start = k + 1;
            end else begin
                m_start = -1;
            end
        end else if (e) begin
            if (m_pend == MAXP) drop = 1'b1;
            else m_pend++;
        end
        e_busy = m_active(c);
        e_sig  = e_busy && ((c - m_start) < H);
        e_done = HAS_DONE && e_busy && ((c - m_start) == H);
        exp_q.push_back({e_sig, e_busy, PW'(m_pend), drop, e_done});
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input bit e, input bit r);
        ev  = e;
        rst = r;
        @(posedge clk);
        model_step(e, r);
        cyc++;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [W-1:0] obs, expv;
        for (int j = 0; j < 3; j++) begin
            drive_cycle(1'b0, 1'b1);
            obs  = {sig, busy, pend_cnt, ovf, done_w};
            expv = exp_q.pop_front();
            n_checks++;
            if (obs !== expv || obs !== '0) begin
                n_fail++;
                $display("FAIL reset cyc %0d: got %b required %b", j, obs, expv);
            end
        end
    endtask

    task automatic test_single();
        logic [W-1:0] obs, expv;
        int sig_hi, busy_hi;
        sig_hi  = 0;
        busy_hi = 0;
        drive_cycle(1'b0, 1'b1);
        void'(exp_q.pop_front());
        for (int j = 0; j < 10; j++) begin
            drive_cycle(j == 0, 1'b0);
            obs  = {sig, busy, pend_cnt, ovf, done_w};
            expv = exp_q.pop_front();
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL single cyc %0d: got {sig,busy,pend,ovf,done}=%b required %b", j + 1, obs, expv);
            end
            if (sig === 1'b1) sig_hi++;
            if (busy === 1'b1) busy_hi++;
        end
        n_checks++;
        if (sig_hi != H || busy_hi != P) begin
            n_fail++;
            $display("FAIL single_width: sig high %0d busy high %0d required %0d %0d", sig_hi, busy_hi, H, P);
        end
    endtask

    task automatic test_burst();
        logic [W-1:0] obs, expv;
        int rises[$];
        int falls;
        logic prev;
        falls = 0;
        prev  = 1'b0;
        drive_cycle(1'b0, 1'b1);
        void'(exp_q.pop_front());
        for (int j = 0; j < 16; j++) begin
            drive_cycle(j < 3, 1'b0);
            obs  = {sig, busy, pend_cnt, ovf, done_w};
            expv = exp_q.pop_front();
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL burst cyc %0d: got {sig,busy,pend,ovf,done}=%b required %b", j + 1, obs, expv);
            end
            if (sig === 1'b1 && prev === 1'b0) rises.push_back(j + 1);
            if (sig === 1'b0 && prev === 1'b1) falls++;
            if (j + 1 == 3 || j + 1 == 6) begin
                n_checks++;
                if (pend_cnt !== PW'(j + 1 == 3 ? 2 : 1)) begin
                    n_fail++;
                    $display("FAIL burst_pend cyc %0d: got %0d required %0d", j + 1, pend_cnt, (j + 1 == 3) ? 2 : 1);
                end
            end
            prev = sig;
        end
        n_checks++;
        if (rises.size() != 3 || falls != 3 || rises[0] != 1 || rises[1] != 6 || rises[2] != 11) begin
            n_fail++;
            $display("FAIL burst_edges: got %0d rises (first %0d) %0d falls required 3 rises at 1,6,11 and 3 falls",
                     rises.size(), (rises.size() > 0) ? rises[0] : -1, falls);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] obs, expv;
        int rises, ovfs, ovf_at;
        logic prev;
        rises  = 0;
        ovfs   = 0;
        ovf_at = -1;
        prev   = 1'b0;
        drive_cycle(1'b0, 1'b1);
        void'(exp_q.pop_front());
        for (int j = 0; j < 22; j++) begin
            drive_cycle(j < 5, 1'b0);
            obs  = {sig, busy, pend_cnt, ovf, done_w};
            expv = exp_q.pop_front();
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL overflow cyc %0d: got {sig,busy,pend,ovf,done}=%b required %b", j + 1, obs, expv);
            end
            if (sig === 1'b1 && prev === 1'b0) rises++;
            if (ovf === 1'b1) begin
                ovfs++;
                ovf_at = j + 1;
            end
            prev = sig;
        end
        n_checks++;
        if (rises != 4 || ovfs != 1 || ovf_at != 5) begin
            n_fail++;
            $display("FAIL overflow_count: got %0d periods, %0d ovf at %0d required 4 periods, 1 ovf at 5", rises, ovfs, ovf_at);
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] obs, expv;
        drive_cycle(1'b0, 1'b1);
        void'(exp_q.pop_front());
        for (int j = 0; j < 17; j++) begin
            drive_cycle(j == 0 || j == 1 || j == P, 1'b0);
            obs  = {sig, busy, pend_cnt, ovf, done_w};
            expv = exp_q.pop_front();
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL simultaneous cyc %0d: got {sig,busy,pend,ovf,done}=%b required %b", j + 1, obs, expv);
            end
            if (j + 1 == P + 1) begin
                n_checks++;
                if (pend_cnt !== PW'(1) || sig !== 1'b1) begin
                    n_fail++;
                    $display("FAIL simultaneous_hold: got pend %0d sig %b required pend 1 sig 1", pend_cnt, sig);
                end
            end
        end
    endtask

    task automatic test_direct_consume();
        logic [W-1:0] obs, expv;
        int busy_hi;
        busy_hi = 0;
        drive_cycle(1'b0, 1'b1);
        void'(exp_q.pop_front());
        for (int j = 0; j < 12; j++) begin
            drive_cycle(j == 0 || j == P, 1'b0);
            obs  = {sig, busy, pend_cnt, ovf, done_w};
            expv = exp_q.pop_front();
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL direct cyc %0d: got {sig,busy,pend,ovf,done}=%b required %b", j + 1, obs, expv);
            end
            if (j + 1 <= 2 * P && busy === 1'b1) busy_hi++;
        end
        n_checks++;
        if (busy_hi != 2 * P) begin
            n_fail++;
            $display("FAIL direct_no_idle: busy high %0d of first %0d cycles, required all", busy_hi, 2 * P);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] obs, expv;
        drive_cycle(1'b0, 1'b1);
        void'(exp_q.pop_front());
        for (int j = 0; j < 12; j++) begin
            drive_cycle(j < 4, j == 7);
            obs  = {sig, busy, pend_cnt, ovf, done_w};
            expv = exp_q.pop_front();
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL reset_mid cyc %0d: got {sig,busy,pend,ovf,done}=%b required %b", j + 1, obs, expv);
            end
            if (j + 1 == 7) begin
                n_checks++;
                if (pend_cnt !== PW'(2) || sig !== 1'b1) begin
                    n_fail++;
                    $display("FAIL reset_mid_setup: got pend %0d sig %b required pend 2 sig 1", pend_cnt, sig);
                end
            end
            if (j + 1 == 8 || j + 1 == 9) begin
                n_checks++;
                if (obs !== '0) begin
                    n_fail++;
                    $display("FAIL reset_mid_clear cyc %0d: got %b required all zero", j + 1, obs);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] obs, expv;
        bit e, r;
        for (int j = 0; j < 600; j++) begin
            e = ($urandom_range(0, 99) < 45);
            r = ($urandom_range(0, 99) == 0);
            drive_cycle(e, r);
            obs  = {sig, busy, pend_cnt, ovf, done_w};
            expv = exp_q.pop_front();
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL random cyc %0d: got {sig,busy,pend,ovf,done}=%b required %b", j, obs, expv);
            end
            n_checks++;
            if ((state_dbg != 2'd0) !== busy) begin
                n_fail++;
                $display("FAIL random_state cyc %0d: state_dbg %0d busy %b", j, state_dbg, busy);
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst = 1'b1;
        ev  = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_simultaneous();
        test_direct_consume();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
